// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Boot-time loader that sits directly upstream of the IF stage. It takes a
// program image from the UART receiver as a byte stream, assembles
// little-endian 32-bit words and writes the instruction words into the
// instruction ROM's write port. The CPU core is held in reset until the
// complete image has arrived and its XOR checksum has matched.
//
// Image layout (each field one little-endian 32-bit word):
//   length N, then N instruction words, then XOR of those N words.
//
// Ports:
//   clk             system clock
//   reset_n         synchronous, active-low reset
//   rx_data         received byte
//   rx_valid        rx_data holds a byte this cycle
//   rx_ready        loader can take a byte (transfer = rx_valid & rx_ready)
//   rom_wren        one-cycle ROM write strobe per instruction word
//   rom_address     byte address of the word being written (multiple of 4)
//   rom_write_data  word being written
//   cpu_reset_n     reset to the CPU core, released only after a good load
//   done            load finished with a matching checksum (sticky)
//   error           load failed (sticky)
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int ADDRESS_BITWIDTH = 12
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic                        rx_ready,
    output logic                        rom_wren,
    output logic [ADDRESS_BITWIDTH-1:0] rom_address,
    output logic [31:0]                 rom_write_data,
    output logic                        cpu_reset_n,
    output logic                        done,
    output logic                        error
);

    // The word counter is one bit wider than the word-address field so that
    // it can hold the full-capacity count after the last word is written.
    localparam int          WORD_COUNT_BITS = ADDRESS_BITWIDTH - 1;
    localparam logic [31:0] CAPACITY        = 32'd1 << (ADDRESS_BITWIDTH - 2);

    typedef enum logic [2:0] {
        LEN,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 byteCount_q, byteCount_d;
    logic [WORD_COUNT_BITS-1:0] wordCount_q, wordCount_d;
    logic [WORD_COUNT_BITS-1:0] length_q, length_d;
    logic [31:0]                assembly_q, assembly_d;
    logic [31:0]                checksum_q, checksum_d;
    logic [ADDRESS_BITWIDTH-1:0] romAddress_q, romAddress_d;
    logic [31:0]                romData_q, romData_d;

    logic        accept;
    logic        wordComplete;
    logic [31:0] wordNow;

    // Output decode depends only on the current state, so rx_ready never
    // depends combinationally on rx_valid.
    always_comb begin
        rx_ready    = 1'b0;
        rom_wren    = 1'b0;
        cpu_reset_n = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        unique case (state_q)
            LEN, DATA, CSUM: rx_ready = 1'b1;
            WRITE:           rom_wren = 1'b1;
            DONE: begin
                done        = 1'b1;
                cpu_reset_n = 1'b1;
            end
            ERROR:           error = 1'b1;
            default:         ;
        endcase
    end

    assign rom_address    = romAddress_q;
    assign rom_write_data = romData_q;

    // Byte assembly plus next-state logic. wordNow is the assembly register
    // with the incoming byte already merged in, so a word can be acted on in
    // the same cycle its 4th byte arrives.
    always_comb begin
        state_d      = state_q;
        byteCount_d  = byteCount_q;
        wordCount_d  = wordCount_q;
        length_d     = length_q;
        assembly_d   = assembly_q;
        checksum_d   = checksum_q;
        romAddress_d = romAddress_q;
        romData_d    = romData_q;

        accept       = rx_valid & rx_ready;
        wordComplete = accept && (byteCount_q == 2'd3);
        wordNow      = assembly_q;
        wordNow[{byteCount_q, 3'b000} +: 8] = rx_data;

        if (accept) begin
            assembly_d  = wordNow;
            byteCount_d = byteCount_q + 2'd1;
        end

        unique case (state_q)
            LEN: begin
                if (wordComplete) begin
                    // Full 32-bit compare: any upper bit set is an oversize image.
                    if (wordNow > CAPACITY) begin
                        state_d = ERROR;
                    end else begin
                        length_d = wordNow[WORD_COUNT_BITS-1:0];
                        state_d  = (wordNow == 32'd0) ? CSUM : DATA;
                    end
                end
            end
            DATA: begin
                if (wordComplete) begin
                    romData_d    = wordNow;
                    romAddress_d = {wordCount_q[WORD_COUNT_BITS-2:0], 2'b00};
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                checksum_d  = checksum_q ^ romData_q;
                wordCount_d = wordCount_q + WORD_COUNT_BITS'(1);
                state_d     = (wordCount_d == length_q) ? CSUM : DATA;
            end
            CSUM: begin
                if (wordComplete) begin
                    state_d = (wordNow == checksum_q) ? DONE : ERROR;
                end
            end
            default: ;
        endcase
    end

    // State register. Reset returns to LEN from anywhere, including mid-load;
    // whatever has already been written into the ROM is left as is.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= LEN;
            byteCount_q  <= '0;
            wordCount_q  <= '0;
            length_q     <= '0;
            assembly_q   <= '0;
            checksum_q   <= '0;
            romAddress_q <= '0;
            romData_q    <= '0;
        end else begin
            state_q      <= state_d;
            byteCount_q  <= byteCount_d;
            wordCount_q  <= wordCount_d;
            length_q     <= length_d;
            assembly_q   <= assembly_d;
            checksum_q   <= checksum_d;
            romAddress_q <= romAddress_d;
            romData_q    <= romData_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Feeds program images byte by byte into program_loader and compares every
// cycle against a reference derived from the image itself: which byte of the
// stream was just taken decides whether a ROM write is due (and with which
// address and word), and the total byte count plus checksum result decide
// when done or error must appear.
// ---------------------------------------------------------------------------
module tb_program_loader;

    localparam int          AW       = 12;
    localparam logic [31:0] CAPACITY = 32'd1 << (AW - 2);

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          rom_wren;
    logic [AW-1:0] rom_address;
    logic [31:0]   rom_write_data;
    logic          cpu_reset_n;
    logic          done;
    logic          error;

    program_loader #(.ADDRESS_BITWIDTH(AW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rom_wren       (rom_wren),
        .rom_address    (rom_address),
        .rom_write_data (rom_write_data),
        .cpu_reset_n    (cpu_reset_n),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    int totalChecks = 0;
    int badChecks   = 0;

    // Current image: length field, instruction words and the checksum sent.
    logic [31:0] imgLen;
    logic [31:0] imgCsum;
    logic [31:0] imgWords[$];
    logic [7:0]  streamBytes[$];

    // Last word the ROM port should be presenting (holds between writes).
    logic [31:0] lastAddr = 32'd0;
    logic [31:0] lastData = 32'd0;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic pushWord(input logic [31:0] w);
        for (int k = 0; k < 4; k++) streamBytes.push_back(w[8*k +: 8]);
    endtask

    function automatic logic [31:0] xorWords();
        logic [31:0] acc = 32'd0;
        foreach (imgWords[i]) acc ^= imgWords[i];
        return acc;
    endfunction

    task automatic randomWords(input int n);
        imgWords.delete();
        for (int i = 0; i < n; i++) imgWords.push_back($urandom);
        imgLen = 32'(n);
    endtask

    // Serialise the image; 8 trailing junk bytes probe that nothing is
    // consumed once the loader has finished.
    task automatic buildStream();
        streamBytes.delete();
        pushWord(imgLen);
        if (imgLen <= CAPACITY) begin
            foreach (imgWords[i]) pushWord(imgWords[i]);
            pushWord(imgCsum);
        end
        for (int i = 0; i < 8; i++) streamBytes.push_back(8'($urandom));
    endtask

    // Hold reset with a byte offered and check the reset values each cycle.
    task automatic applyReset(input int cycles);
        reset_n  = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        lastAddr = 32'd0;
        lastData = 32'd0;
        repeat (cycles) begin
            @(negedge clk);
            checkOutput("rst_rx_ready", 32'(rx_ready), 32'd1);
            checkOutput("rst_rom_wren", 32'(rom_wren), 32'd0);
            checkOutput("rst_rom_address", 32'(rom_address), 32'd0);
            checkOutput("rst_rom_write_data", rom_write_data, 32'd0);
            checkOutput("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
            checkOutput("rst_done", 32'(done), 32'd0);
            checkOutput("rst_error", 32'(error), 32'd0);
        end
        reset_n  = 1'b1;
        rx_valid = 1'b0;
    endtask

    // Stream the current image. mode 0: continuous, 1: valid every other
    // cycle, 2: random gaps. abortAt > 0 returns right after that many bytes
    // have been taken so the caller can reset mid-load.
    task automatic applyStimulus(input int mode, input int abortAt);
        int          taken      = 0;
        int          cycles     = 0;
        int          postCycles = 0;
        int          total;
        int          budget;
        int          b;
        int          w;
        bit          lenOk;
        bit          csumOk;
        bit          justTaken;
        bit          readySeen  = 1'b0;
        bit          wrenExp;
        bit          doneExp;
        bit          errExp;
        logic [31:0] refXor;

        lenOk  = (imgLen <= CAPACITY);
        refXor = xorWords();
        csumOk = (imgCsum == refXor);
        total  = lenOk ? 8 + 4 * int'(imgLen) : 4;
        budget = 6 * total + 100;
        rx_valid = 1'b0;

        while (cycles < budget && postCycles < 16) begin
            @(negedge clk);
            cycles++;
            justTaken = rx_valid && readySeen;
            if (justTaken) taken++;

            b = taken - 1;
            w = b / 4;
            wrenExp = justTaken && (b % 4 == 3) && lenOk && (w >= 1) && (w <= int'(imgLen));
            if (wrenExp) begin
                lastAddr = 32'((w - 1) * 4);
                lastData = imgWords[w - 1];
            end
            doneExp = lenOk && csumOk && (taken >= total);
            errExp  = (!lenOk && taken >= 4) || (lenOk && !csumOk && taken >= total);

            checkOutput("rom_wren", 32'(rom_wren), 32'(wrenExp));
            checkOutput("rom_address", 32'(rom_address), lastAddr);
            checkOutput("rom_write_data", rom_write_data, lastData);
            checkOutput("rx_ready", 32'(rx_ready), 32'(!(wrenExp || doneExp || errExp)));
            checkOutput("done", 32'(done), 32'(doneExp));
            checkOutput("error", 32'(error), 32'(errExp));
            checkOutput("cpu_reset_n", 32'(cpu_reset_n), 32'(doneExp));

            if (abortAt > 0 && taken == abortAt) return;
            if (taken >= total) postCycles++;

            readySeen = rx_ready;
            // A byte offered but not yet taken is held unchanged.
            if (justTaken || !rx_valid) begin
                if (taken < streamBytes.size()) begin
                    case (mode)
                        0:       rx_valid = 1'b1;
                        1:       rx_valid = !justTaken;
                        default: rx_valid = ($urandom_range(0, 2) != 0);
                    endcase
                    rx_data = rx_valid ? streamBytes[taken] : 8'($urandom);
                end else begin
                    rx_valid = 1'b0;
                end
            end
        end
        checkOutput("bytes_taken", 32'(taken), 32'(total));
        rx_valid = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        $display("[TB] program_loader bench start");

        applyReset(3);

        $display("[TB] two-word image, continuous");
        imgWords = {32'h0000_0013, 32'h0010_0093};
        imgLen   = 32'd2;
        imgCsum  = 32'h0010_0080;
        buildStream();
        applyStimulus(0, 0);

        $display("[TB] two-word image, bad checksum");
        applyReset(1);
        imgCsum = 32'h0010_0081;
        buildStream();
        applyStimulus(0, 0);

        $display("[TB] empty image");
        applyReset(1);
        imgWords.delete();
        imgLen  = 32'd0;
        imgCsum = 32'd0;
        buildStream();
        applyStimulus(0, 0);

        $display("[TB] oversize lengths");
        applyReset(1);
        imgLen = CAPACITY + 32'd1;
        buildStream();
        applyStimulus(0, 0);
        applyReset(1);
        imgLen = 32'h0001_0003;
        buildStream();
        applyStimulus(2, 0);

        $display("[TB] full-capacity image");
        applyReset(1);
        randomWords(int'(CAPACITY));
        imgCsum = xorWords();
        buildStream();
        applyStimulus(0, 0);

        $display("[TB] two-word image, gapped");
        applyReset(1);
        imgWords = {32'h0000_0013, 32'h0010_0093};
        imgLen   = 32'd2;
        imgCsum  = 32'h0010_0080;
        buildStream();
        applyStimulus(1, 0);

        $display("[TB] reset mid-load then fresh image");
        applyReset(1);
        randomWords(5);
        imgCsum = xorWords();
        buildStream();
        applyStimulus(0, 6);
        applyReset(2);
        randomWords(7);
        imgCsum = xorWords();
        buildStream();
        applyStimulus(2, 0);

        $display("[TB] random images");
        for (int i = 0; i < 6; i++) begin
            applyReset(1);
            randomWords($urandom_range(0, 24));
            imgCsum = xorWords();
            if ($urandom_range(0, 3) == 0) imgCsum ^= (32'd1 << $urandom_range(0, 31));
            buildStream();
            applyStimulus($urandom_range(0, 2), 0);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
